// File: rtl/cmd_issue_fifo_pkg.sv
// Shared types, widths and DDR3 pin encodings for the command issue FIFO.
package cmd_issue_fifo_pkg;

   localparam int unsigned BA_BITS   = 3;
   localparam int unsigned ADDR_BITS = 14;
   localparam int unsigned ROW_BITS  = 14;
   localparam int unsigned COL_BITS  = 10;
   localparam int unsigned A10_BIT   = 10;

   typedef enum logic [3:0] {
      ATCMD_NOP       = 4'd0,
      ATCMD_ACTIVE    = 4'd1,
      ATCMD_READ      = 4'd2,
      ATCMD_WRITE     = 4'd3,
      ATCMD_RDA       = 4'd4,
      ATCMD_WRA       = 4'd5,
      ATCMD_PRECHARGE = 4'd6,
      ATCMD_REFRESH   = 4'd7,
      ATCMD_POWER_D   = 4'd8,
      ATCMD_POWER_U   = 4'd9
   } sch_cmd_t;

   typedef struct packed {
      logic [ROW_BITS-1:0] row;
      logic [COL_BITS-1:0] col;
   } cmd_addr_t;

   typedef struct packed {
      sch_cmd_t            command;
      cmd_addr_t           addr;
      logic [BA_BITS-1:0]  bank;
   } issue_fifo_cmd_in_t;

   typedef struct packed {
      logic cs_n;
      logic ras_n;
      logic cas_n;
      logic we_n;
   } ddr_pin_cmd_t;

   localparam ddr_pin_cmd_t PIN_NOP   = ddr_pin_cmd_t'(4'b0111);
   localparam ddr_pin_cmd_t PIN_ACT   = ddr_pin_cmd_t'(4'b0011);
   localparam ddr_pin_cmd_t PIN_RD    = ddr_pin_cmd_t'(4'b0101);
   localparam ddr_pin_cmd_t PIN_WR    = ddr_pin_cmd_t'(4'b0100);
   localparam ddr_pin_cmd_t PIN_PRE   = ddr_pin_cmd_t'(4'b0010);
   localparam ddr_pin_cmd_t PIN_REF   = ddr_pin_cmd_t'(4'b0001);
   localparam ddr_pin_cmd_t PIN_DESEL = ddr_pin_cmd_t'(4'b1111);

   // Power-state and NOP entries drive NOP on the pins.
   function automatic ddr_pin_cmd_t pin_code(input sch_cmd_t cmd);
      ddr_pin_cmd_t p;
      case (cmd)
         ATCMD_ACTIVE:           p = PIN_ACT;
         ATCMD_READ, ATCMD_RDA:  p = PIN_RD;
         ATCMD_WRITE, ATCMD_WRA: p = PIN_WR;
         ATCMD_PRECHARGE:        p = PIN_PRE;
         ATCMD_REFRESH:          p = PIN_REF;
         default:                p = PIN_NOP;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/issue_sync_fifo.sv
// Synchronous FIFO storage with wrap-around pointers and exact occupancy count.
module issue_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             pop_i,
   output logic [W-1:0]     head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, full_q;
   logic             push_c, pop_c;

   // A full FIFO refuses pushes even when it pops in the same cycle.
   assign push_c = push_i & ~full_q;
   assign pop_c  = pop_i & ~empty_q;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_c) wr_d = wr_q + PTR_W'(1);
      if (pop_c)  rd_d = rd_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CNT_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/cmd_issue_fifo.sv
// Buffers scheduler commands and drives registered DDR3 command/address pins and CKE.
// Optional CMD_ISSUE_BYPASS_EN lets a command skip storage when the FIFO is empty.
module cmd_issue_fifo
   import cmd_issue_fifo_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_valid,
   input  issue_fifo_cmd_in_t   push_cmd,
   output logic                 push_ready,
   input  logic                 issue_stall,
   output logic                 ddr_cke,
   output logic                 ddr_cs_n,
   output logic                 ddr_ras_n,
   output logic                 ddr_cas_n,
   output logic                 ddr_we_n,
   output logic [BA_BITS-1:0]   ddr_ba,
   output logic [ADDR_BITS-1:0] ddr_addr,
   output sch_cmd_t             issued_cmd,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 fifo_empty
);

   localparam int unsigned CMD_W = $bits(issue_fifo_cmd_in_t);

   logic [CMD_W-1:0]   head_raw;
   issue_fifo_cmd_in_t head_c, sel_c;
   logic               fifo_full;
   logic               push_fire_c, pop_c, bypass_c, store_c, issue_c;

   ddr_pin_cmd_t          pins_q, pins_d;
   logic [BA_BITS-1:0]    ba_q, ba_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic                  cke_q, cke_d;
   sch_cmd_t              issued_q, issued_d;

   issue_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CMD_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (store_c),
      .data_i  (push_cmd),
      .pop_i   (pop_c),
      .head_o  (head_raw),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign head_c      = issue_fifo_cmd_in_t'(head_raw);
   assign push_ready  = ~fifo_full;
   assign push_fire_c = push_valid & ~fifo_full;

   // While CKE is low only a power-up command may leave the FIFO.
   assign pop_c = ~fifo_empty & ~issue_stall &
                  (cke_q | (head_c.command == ATCMD_POWER_U));

`ifdef CMD_ISSUE_BYPASS_EN
   assign bypass_c = fifo_empty & push_fire_c & ~issue_stall &
                     (cke_q | (push_cmd.command == ATCMD_POWER_U));
`else
   assign bypass_c = 1'b0;
`endif

   assign store_c = push_fire_c & ~bypass_c;
   assign issue_c = pop_c | bypass_c;
   assign sel_c   = bypass_c ? push_cmd : head_c;

   always_comb begin
      pins_d   = PIN_NOP;
      ba_d     = '0;
      addr_d   = '0;
      issued_d = ATCMD_NOP;
      cke_d    = cke_q;
      if (issue_c) begin
         issued_d = sel_c.command;
         pins_d   = pin_code(sel_c.command);
         case (sel_c.command)
            ATCMD_ACTIVE: begin
               ba_d   = sel_c.bank;
               addr_d = ADDR_BITS'(sel_c.addr.row);
            end
            ATCMD_READ, ATCMD_WRITE, ATCMD_RDA, ATCMD_WRA: begin
               ba_d            = sel_c.bank;
               addr_d          = ADDR_BITS'(sel_c.addr.col);
               addr_d[A10_BIT] = (sel_c.command == ATCMD_RDA) ||
                                 (sel_c.command == ATCMD_WRA);
            end
            ATCMD_PRECHARGE: ba_d  = sel_c.bank;
            ATCMD_POWER_D:   cke_d = 1'b0;
            ATCMD_POWER_U:   cke_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pins_q   <= PIN_DESEL;
         ba_q     <= '0;
         addr_q   <= '0;
         cke_q    <= 1'b0;
         issued_q <= ATCMD_NOP;
      end else begin
         pins_q   <= pins_d;
         ba_q     <= ba_d;
         addr_q   <= addr_d;
         cke_q    <= cke_d;
         issued_q <= issued_d;
      end
   end

   assign ddr_cs_n   = pins_q.cs_n;
   assign ddr_ras_n  = pins_q.ras_n;
   assign ddr_cas_n  = pins_q.cas_n;
   assign ddr_we_n   = pins_q.we_n;
   assign ddr_ba     = ba_q;
   assign ddr_addr   = addr_q;
   assign ddr_cke    = cke_q;
   assign issued_cmd = issued_q;

endmodule

// File: tb/tb_cmd_issue_fifo.sv
// Scoreboard bench for cmd_issue_fifo: queue-based reference model plus in-order pin checker.
`timescale 1ns/1ps
module tb_cmd_issue_fifo;
   import cmd_issue_fifo_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 push_valid = 1'b0;
   logic                 issue_stall = 1'b0;
   issue_fifo_cmd_in_t   push_cmd = '0;
   logic                 push_ready;
   logic                 ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
   logic [BA_BITS-1:0]   ddr_ba;
   logic [ADDR_BITS-1:0] ddr_addr;
   sch_cmd_t             issued_cmd;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_empty;

   always #5 clk = ~clk;

   cmd_issue_fifo #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_cmd(push_cmd),
      .push_ready(push_ready), .issue_stall(issue_stall), .ddr_cke(ddr_cke),
      .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n),
      .ddr_we_n(ddr_we_n), .ddr_ba(ddr_ba), .ddr_addr(ddr_addr),
      .issued_cmd(issued_cmd), .fifo_count(fifo_count), .fifo_empty(fifo_empty)
   );

   typedef struct {
      sch_cmd_t             cmd;
      logic [3:0]           pins;
      logic [BA_BITS-1:0]   ba;
      logic [ADDR_BITS-1:0] addr;
   } exp_t;

   // Expected pin image of a command, straight from the DDR3 command truth table.
   function automatic exp_t exp_of(input issue_fifo_cmd_in_t c);
      exp_t e;
      e.cmd = c.command; e.pins = 4'b0111; e.ba = '0; e.addr = '0;
      case (c.command)
         ATCMD_ACTIVE:    begin e.pins = 4'b0011; e.ba = c.bank; e.addr = c.addr.row; end
         ATCMD_READ:      begin e.pins = 4'b0101; e.ba = c.bank; e.addr = {4'b0000, c.addr.col}; end
         ATCMD_RDA:       begin e.pins = 4'b0101; e.ba = c.bank; e.addr = {3'b000, 1'b1, c.addr.col}; end
         ATCMD_WRITE:     begin e.pins = 4'b0100; e.ba = c.bank; e.addr = {4'b0000, c.addr.col}; end
         ATCMD_WRA:       begin e.pins = 4'b0100; e.ba = c.bank; e.addr = {3'b000, 1'b1, c.addr.col}; end
         ATCMD_PRECHARGE: begin e.pins = 4'b0010; e.ba = c.bank; end
         ATCMD_REFRESH:   e.pins = 4'b0001;
         default: ;
      endcase
      return e;
   endfunction

   // Reference model state (written only by the model process).
   issue_fifo_cmd_in_t mq[$];
   exp_t               exp_q[$];
   int                 exp_skip = 0;
   logic               m_cke = 1'b0;
   logic               m_desel = 1'b1;
   logic               chk_en = 1'b0;
   sch_cmd_t           m_cmd = ATCMD_NOP;
   issue_fifo_cmd_in_t m_c;
   logic               m_acc, m_iss;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         exp_skip = exp_q.size();
         m_cke = 1'b0; m_desel = 1'b1; m_cmd = ATCMD_NOP; chk_en = 1'b1;
      end else begin
         m_acc = push_valid && (mq.size() < DEPTH);
         m_iss = 1'b0;
         m_desel = 1'b0;
         m_cmd = ATCMD_NOP;
         m_c = '0;
         if (m_acc && push_cmd.command != ATCMD_NOP) exp_q.push_back(exp_of(push_cmd));
         if (mq.size() != 0 && !issue_stall && (m_cke || mq[0].command == ATCMD_POWER_U)) begin
            m_c = mq.pop_front(); m_iss = 1'b1;
         end
`ifdef CMD_ISSUE_BYPASS_EN
         else if (mq.size() == 0 && m_acc && !issue_stall &&
                  (m_cke || push_cmd.command == ATCMD_POWER_U)) begin
            m_c = push_cmd; m_iss = 1'b1; m_acc = 1'b0;
         end
`endif
         if (m_acc) mq.push_back(push_cmd);
         if (m_iss) begin
            m_cmd = m_c.command;
            if (m_c.command == ATCMD_POWER_D) m_cke = 1'b0;
            if (m_c.command == ATCMD_POWER_U) m_cke = 1'b1;
         end
      end
   end

   // Checker state (written only by the monitor process).
   int   total = 0;
   int   bad = 0;
   int   exp_rd = 0;
   exp_t e_m;
   logic final_req = 1'b0;
   logic final_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("issued_cmd", 32'(issued_cmd), 32'(m_cmd));
         check("cke",        32'(ddr_cke), 32'(m_cke));
         check("fifo_count", 32'(fifo_count), 32'(mq.size()));
         check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
         check("push_ready", 32'(push_ready), 32'(mq.size() < DEPTH));
         if (issued_cmd != ATCMD_NOP) begin
            if (exp_rd < exp_skip) exp_rd = exp_skip;
            if (exp_rd >= exp_q.size()) begin
               check("sb_unexpected_issue", 32'(issued_cmd), 32'(ATCMD_NOP));
            end else begin
               e_m = exp_q[exp_rd];
               exp_rd++;
               check("sb_cmd",  32'(issued_cmd), 32'(e_m.cmd));
               check("sb_pins", 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'(e_m.pins));
               check("sb_ba",   32'(ddr_ba), 32'(e_m.ba));
               check("sb_addr", 32'(ddr_addr), 32'(e_m.addr));
            end
         end else begin
            check("idle_pins", 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}),
                  m_desel ? 32'hF : 32'h7);
            check("idle_ba",   32'(ddr_ba), 32'h0);
            check("idle_addr", 32'(ddr_addr), 32'h0);
         end
      end
      if (final_req && !final_done) begin
         if (exp_rd < exp_skip) exp_rd = exp_skip;
         check("sb_drained", 32'(exp_q.size() - exp_rd), 32'h0);
         check("model_empty_vs_dut", 32'(fifo_empty), 32'h1);
         final_done = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input sch_cmd_t c, input logic [2:0] ba,
                       input logic [13:0] row, input logic [9:0] col);
      int n;
      n = 0;
      push_valid = 1'b1;
      push_cmd.command  = c;
      push_cmd.bank     = ba;
      push_cmd.addr.row = row;
      push_cmd.addr.col = col;
      while (!push_ready && n < 200) begin
         tick();
         n++;
      end
      tick();
      push_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      // CKE comes out of reset low; power up before normal traffic.
      push(ATCMD_POWER_U, 3'd0, 14'h0, 10'h0);
      idle(2);
      push(ATCMD_ACTIVE, 3'd2, 14'h1A5, 10'h0);
      idle(3);
      push(ATCMD_WRA, 3'd1, 14'h0, 10'h03F);
      idle(3);
      // Fill while stalled: the ninth offer must be refused.
      issue_stall = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_valid = 1'b1;
         push_cmd.command  = (i % 2 == 0) ? ATCMD_READ : ATCMD_PRECHARGE;
         push_cmd.bank     = 3'(i);
         push_cmd.addr.row = 14'(i * 3);
         push_cmd.addr.col = 10'(i * 5 + 1);
         tick();
      end
      push_valid = 1'b0;
      idle(2);
      issue_stall = 1'b0;
      idle(12);
      push(ATCMD_POWER_D, 3'd0, 14'h0, 10'h0);
      idle(3);
      push(ATCMD_POWER_U, 3'd0, 14'h0, 10'h0);
      push(ATCMD_READ, 3'd3, 14'h0, 10'h005);
      idle(4);
      // Reset with five entries queued.
      issue_stall = 1'b1;
      for (int i = 0; i < 5; i++) push(ATCMD_REFRESH, 3'(i), 14'(i), 10'(i));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      issue_stall = 1'b0;
      idle(5);
      // CKE low after reset: a READ is held at the head.
      push(ATCMD_READ, 3'd4, 14'h0, 10'h011);
      idle(6);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      push(ATCMD_POWER_U, 3'd0, 14'h0, 10'h0);
      idle(2);
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            issue_stall = 1'b0;
            push(ATCMD_POWER_D, 3'd0, 14'h0, 10'h0);
            push(ATCMD_POWER_U, 3'd0, 14'h0, 10'h0);
         end else begin
            issue_stall = ($urandom_range(0, 3) == 0);
            push_valid  = 1'($urandom_range(0, 1));
            push_cmd.command  = sch_cmd_t'(4'($urandom_range(0, 7)));
            push_cmd.bank     = 3'($urandom);
            push_cmd.addr.row = 14'($urandom);
            push_cmd.addr.col = 10'($urandom);
            tick();
         end
      end
      push_valid = 1'b0;
      issue_stall = 1'b0;
      n = 0;
      while (mq.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      idle(3);
      final_req = 1'b1;
      n = 0;
      while (!final_done && n < 10) begin
         tick();
         n++;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
